// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-unit definitions: state encodings, reset vector, instruction width.
// FETCH_TIMEOUT_EN adds the FAULT state used by the bus wait-state watchdog.
package instruction_fetch_pkg;

    localparam int unsigned INSTR_WIDTH  = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_ISSUE = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3
`ifdef FETCH_TIMEOUT_EN
        , ST_FAULT = 3'd4
`endif
    } fetch_state_e;

    function automatic logic is_bus_state(input fetch_state_e s);
        return (s == ST_FETCH) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit signal bundle: PC side, instruction bus and decoder handshake.
// master = fetch sequencer view, slave = surrounding CPU / bus view.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pcIn;
    logic                  pcCountEnable;
    logic [ADDR_WIDTH-1:0] busAddress;
    logic                  busReadEnable;
    logic                  busReady;
    logic [DATA_WIDTH-1:0] busDataIn;
    logic [DATA_WIDTH-1:0] instrOut;
    logic                  instrValid;
    logic                  instrReady;
    logic                  jumpRequest;
    logic                  busError;

    modport master (
        input  pcIn, busReady, busDataIn, instrReady, jumpRequest,
        output pcCountEnable, busAddress, busReadEnable, instrOut, instrValid, busError
    );

    modport slave (
        output pcIn, busReady, busDataIn, instrReady, jumpRequest,
        input  pcCountEnable, busAddress, busReadEnable, instrOut, instrValid, busError
    );
endinterface

// File: rtl/instruction_fetch_watchdog.sv
// Bus wait-state watchdog: down-counter reloaded while not waiting, expires on the
// TIMEOUT_CYCLES-th consecutive wait cycle. Only instantiated with FETCH_TIMEOUT_EN.
module instruction_fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic restart,
    output logic expire
);
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= CNT_LOAD;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !waiting)   cnt_d = CNT_LOAD;
        else if (cnt_q != '0)      cnt_d = cnt_q - CNT_W'(1);
    end

    assign expire = waiting && (cnt_q == CNT_W'(1));
endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: latch PC, single outstanding bus read, hold word for decoder.
// FETCH_TIMEOUT_EN enables the bus wait-state watchdog and FAULT state.
//
// state | meaning
// ISSUE | latch pcIn as the read address
// FETCH | read outstanding, capture data on busReady
// HOLD  | instruction valid, waiting for decoder
// DRAIN | read outstanding after a jump, data discarded
// FAULT | bus timed out, busError held until jumpRequest
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = INSTR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master fif
);
    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    logic expire;
    logic restart;

    assign restart = (state_d != state_q);

    instruction_fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .waiting (is_bus_state(state_q) && !fif.busReady),
        .restart (restart),
        .expire  (expire)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ISSUE;
            addr_q  <= ADDR_WIDTH'(RESET_VECTOR);
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            // A jump in ISSUE means pcIn is being rewritten; re-latch next cycle.
            ST_ISSUE: begin
                if (!fif.jumpRequest) begin
                    addr_d  = fif.pcIn;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fif.busReady) begin
                    if (!fif.jumpRequest) begin
                        instr_d = fif.busDataIn;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (fif.jumpRequest) begin
                    state_d = ST_DRAIN;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (expire) begin
                    state_d = ST_FAULT;
                end
`endif
            end
            ST_DRAIN: begin
                if (fif.busReady) state_d = ST_ISSUE;
`ifdef FETCH_TIMEOUT_EN
                else if (expire) state_d = ST_FAULT;
`endif
            end
            ST_HOLD: begin
                if (fif.jumpRequest || fif.instrReady) state_d = ST_ISSUE;
            end
`ifdef FETCH_TIMEOUT_EN
            ST_FAULT: begin
                if (fif.jumpRequest) state_d = ST_ISSUE;
            end
`endif
            default: state_d = ST_ISSUE;
        endcase
    end

    always_comb begin
        fif.busReadEnable = is_bus_state(state_q);
        fif.instrValid    = (state_q == ST_HOLD);
        fif.pcCountEnable = (state_q == ST_HOLD) && fif.instrReady && !fif.jumpRequest;
        fif.busError      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        fif.busError      = (state_q == ST_FAULT);
`endif
    end

    assign fif.busAddress = addr_q;
    assign fif.instrOut   = instr_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC/bus plant and an expected-instruction queue.
// Timeout scenario runs only when FETCH_TIMEOUT_EN is defined.
module tb_instruction_fetch;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    instruction_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fif ();

    instruction_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          n_cnt = 0;
    int          waits_done = 0;
    int          wait_n = 0;
    logic [31:0] pc = 32'h0;
    logic [31:0] jmp_target = 32'h0;
    logic [31:0] fetch_addr = 32'h0;
    logic        cur_jmp = 1'b0;
    logic        cur_rdy = 1'b0;
    exp_t        sb[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a << 4) | 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.a = a;
        e.d = mem(a);
        sb.push_back(e);
    endtask

    // Apply this cycle's inputs (bus plant answers from its wait budget), then settle.
    task automatic drive(input logic jmp, input logic rdy);
        cur_jmp = jmp;
        cur_rdy = rdy;
        fif.pcIn        = pc;
        fif.jumpRequest = jmp;
        fif.instrReady  = rdy;
        fif.busReady    = fif.busReadEnable && (waits_done >= wait_n);
        fif.busDataIn   = mem(fif.busAddress);
        #1;
    endtask

    task automatic adv();
        exp_t e;
        if (fif.pcCountEnable) begin
            n_cnt++;
            chk("cnt_legal", {62'd0, fif.instrValid, cur_jmp}, 64'd2);
        end
        if (fif.instrValid && cur_rdy && !cur_jmp) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr_data", 64'(fif.instrOut), 64'(e.d));
                chk("instr_addr", 64'(fetch_addr), 64'(e.a));
            end
        end
        if (fif.busReadEnable && fif.busReady) begin
            fetch_addr = fif.busAddress;
            waits_done = 0;
        end else if (fif.busReadEnable) begin
            waits_done++;
        end else begin
            waits_done = 0;
        end
        if (cur_jmp) pc = jmp_target;
        else if (fif.pcCountEnable) pc = pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        fif.pcIn        = '0;
        fif.jumpRequest = 1'b0;
        fif.instrReady  = 1'b0;
        fif.busReady    = 1'b0;
        fif.busDataIn   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr",  64'(fif.busAddress), 64'd0);
        chk("rst_ren",   64'(fif.busReadEnable), 64'd0);
        chk("rst_instr", 64'(fif.instrOut), 64'd0);
        chk("rst_valid", 64'(fif.instrValid), 64'd0);
        chk("rst_cnt",   64'(fif.pcCountEnable), 64'd0);
        chk("rst_err",   64'(fif.busError), 64'd0);
        reset = 1'b1;

        // first fetch after reset, zero-wait bus
        pc = 32'h0;
        wait_n = 0;
        push(32'h0);
        drive(0, 0); chk("t1_c0_ren", 64'(fif.busReadEnable), 64'd0); adv();
        drive(0, 0);
        chk("t1_c1_ren", 64'(fif.busReadEnable), 64'd1);
        chk("t1_c1_addr", 64'(fif.busAddress), 64'd0);
        adv();
        drive(0, 0);
        chk("t1_c2_valid", 64'(fif.instrValid), 64'd1);
        chk("t1_c2_instr", 64'(fif.instrOut), 64'h13);
        chk("t1_c2_nocnt", 64'(fif.pcCountEnable), 64'd0);
        adv();
        drive(0, 1); chk("t1_accept_cnt", 64'(fif.pcCountEnable), 64'd1); adv();

        // back-to-back fetches 0x4..0x40
        base = n_cnt;
        for (int i = 1; i <= 16; i++) push(32'(i * 4));
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1); adv();
            drive(0, 1); chk("t2_addr", 64'(fif.busAddress), 64'(i * 4)); adv();
            drive(0, 1); chk("t2_valid", 64'(fif.instrValid), 64'd1); adv();
        end
        chk("t2_cnt_total", 64'(n_cnt - base), 64'd16);

        // five bus wait states
        wait_n = 5;
        push(32'h44);
        drive(0, 0); adv();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0);
            chk("t3_ren", 64'(fif.busReadEnable), 64'd1);
            chk("t3_addr", 64'(fif.busAddress), 64'h44);
            chk("t3_valid_low", 64'(fif.instrValid), 64'd0);
            adv();
        end
        drive(0, 1); chk("t3_valid", 64'(fif.instrValid), 64'd1); adv();

        // jump while read is waiting -> DRAIN, stale data dropped
        wait_n = 3;
        jmp_target = 32'hDEAD_BEEC;
        base = n_cnt;
        drive(0, 0); adv();
        drive(1, 0); chk("t4_fetch_ren", 64'(fif.busReadEnable), 64'd1); adv();
        drive(1, 1);
        chk("t4_drain_ren", 64'(fif.busReadEnable), 64'd1);
        chk("t4_drain_valid", 64'(fif.instrValid), 64'd0);
        adv();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1);
            chk("t4_drain_ren", 64'(fif.busReadEnable), 64'd1);
            chk("t4_drain_valid", 64'(fif.instrValid), 64'd0);
            adv();
        end
        wait_n = 0;
        push(32'hDEAD_BEEC);
        drive(0, 0); chk("t4_issue_ren", 64'(fif.busReadEnable), 64'd0); adv();
        drive(0, 0); chk("t4_jump_addr", 64'(fif.busAddress), 64'hDEAD_BEEC); adv();
        chk("t4_no_cnt", 64'(n_cnt - base), 64'd0);
        drive(0, 1); adv();

        // jump and instrReady together in HOLD
        jmp_target = 32'h100;
        base = n_cnt;
        drive(0, 0); adv();
        drive(0, 0); adv();
        drive(1, 1);
        chk("t5_hold_valid", 64'(fif.instrValid), 64'd1);
        chk("t5_hold_nocnt", 64'(fif.pcCountEnable), 64'd0);
        adv();
        drive(0, 0); chk("t5_dropped", 64'(fif.instrValid), 64'd0); adv();
        push(32'h100);
        drive(0, 0); chk("t5_jump_addr", 64'(fif.busAddress), 64'h100); adv();
        chk("t5_no_cnt", 64'(n_cnt - base), 64'd0);
        drive(0, 1); adv();

        // jump coinciding with busReady in FETCH: data discarded
        jmp_target = 32'h200;
        drive(0, 0); adv();
        drive(1, 0); chk("t5b_ready", 64'(fif.busReady), 64'd1); adv();
        drive(0, 0); chk("t5b_no_hold", 64'(fif.instrValid), 64'd0); adv();
        push(32'h200);
        drive(0, 0); chk("t5b_addr", 64'(fif.busAddress), 64'h200); adv();
        drive(0, 1); adv();

`ifdef FETCH_TIMEOUT_EN
        // bus never answers -> FAULT, cleared by jump
        wait_n = 1000;
        drive(0, 0); adv();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0);
            chk("t6_err_low", 64'(fif.busError), 64'd0);
            chk("t6_ren", 64'(fif.busReadEnable), 64'd1);
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0);
            chk("t6_err", 64'(fif.busError), 64'd1);
            chk("t6_fault_ren", 64'(fif.busReadEnable), 64'd0);
            chk("t6_fault_valid", 64'(fif.instrValid), 64'd0);
            adv();
        end
        wait_n = 0;
        jmp_target = 32'h300;
        drive(1, 0); adv();
        drive(0, 0); chk("t6_err_clear", 64'(fif.busError), 64'd0); adv();
        push(32'h300);
        drive(0, 0); chk("t6_resume_addr", 64'(fif.busAddress), 64'h300); adv();
        drive(0, 1); adv();
`else
        drive(0, 0); chk("t6_err_tied", 64'(fif.busError), 64'd0); adv();
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
